// File: rtl/distram_req_ctrl_if.sv
// distram_req_ctrl bus bundle: write, read-request, response and RAM ports.
// slave = controller side, master = requester/RAM side.
interface distram_req_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 14,
  parameter int TAG_W  = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_W-1:0]     rd_req_addr;
  logic [TAG_W-1:0]      rd_req_tag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic [TAG_W-1:0]      rsp_tag;

  logic                  mem_ena;
  logic [DATA_W-1:0]     mem_wea;
  logic [ADDR_W-1:0]     mem_addra;
  logic [DATA_W-1:0]     mem_dina;
  logic                  mem_enb;
  logic [ADDR_W-1:0]     mem_addrb;
  logic [DATA_W-1:0]     mem_doutb;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be,
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    input  rsp_ready, mem_doutb,
    output wr_ready, rd_req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    output mem_ena, mem_wea, mem_addra, mem_dina,
    output mem_enb, mem_addrb
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be,
    output rd_req_valid, rd_req_addr, rd_req_tag,
    output rsp_ready, mem_doutb,
    input  wr_ready, rd_req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    input  mem_ena, mem_wea, mem_addra, mem_dina,
    input  mem_enb, mem_addrb
  );
endinterface

// File: rtl/distram_req_ctrl.sv
// Request/response front-end for a 1-cycle read_first simple-dual-port RAM.
// Ports: clk, reset_n (async low), bus (slave: wr/rd_req/rsp/mem groups).
module distram_req_ctrl #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 14,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  distram_req_ctrl_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(RSP_DEPTH - 1);

  logic               run_q;
  logic               infl_q;
  logic [TAG_W-1:0]   infl_tag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;

  logic [DATA_W-1:0]  buf_data [RSP_DEPTH];
  logic [TAG_W-1:0]   buf_tag  [RSP_DEPTH];

  logic rd_acc;
  logic push;
  logic pop;
  logic rsp_vld;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // write path
  assign bus.wr_ready  = run_q;
  assign bus.mem_ena   = bus.wr_valid & run_q;
  assign bus.mem_addra = bus.wr_addr;
  assign bus.mem_dina  = bus.wr_data;

  always_comb begin
    bus.mem_wea = '0;
    for (int b = 0; b < BE_W; b++) begin
      bus.mem_wea[8*b +: 8] = {8{bus.wr_be[b] & bus.mem_ena}};
    end
  end

  // read issue: credit covers the in-flight read plus buffered entries,
  // so the ready never depends on rsp_ready
  assign bus.rd_req_ready =
    run_q & ((CNT_W'(infl_q) + cnt_q) < DEPTH_C);
  assign rd_acc        = bus.rd_req_valid & bus.rd_req_ready;
  assign bus.mem_enb   = rd_acc;
  assign bus.mem_addrb = bus.rd_req_addr;

  // response FIFO
  assign push    = infl_q;
  assign rsp_vld = (cnt_q != '0);
  assign pop     = rsp_vld & bus.rsp_ready;

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_vld ? buf_data[rd_ptr_q] : '0;
  assign bus.rsp_tag   = rsp_vld ? buf_tag[rd_ptr_q]  : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      infl_q     <= 1'b0;
      infl_tag_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      run_q  <= 1'b1;
      infl_q <= rd_acc;
      if (rd_acc) infl_tag_q <= bus.rd_req_tag;
      if (push)   wr_ptr_q   <= nxt(wr_ptr_q);
      if (pop)    rd_ptr_q   <= nxt(rd_ptr_q);
      unique case (1'b1)
        (push & ~pop): cnt_q <= cnt_q + 1'b1;
        (pop & ~push): cnt_q <= cnt_q - 1'b1;
        default:       cnt_q <= cnt_q;
      endcase
    end
  end

  // storage holds no reset; entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= bus.mem_doutb;
      buf_tag[wr_ptr_q]  <= infl_tag_q;
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!reset_n)
    push |-> (cnt_q != DEPTH_C)
  );

endmodule
